// File: rtl/user_id_pkg.sv
// Shared definitions for the user ID readout block: FSM states, CRC default
// polynomial and the readout word width.
package user_id_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;

  typedef enum logic [1:0] {
    ST_SNAP,
    ST_SCAN,
    ST_READY,
    ST_SHIFT
  } state_t;

endpackage

// File: rtl/user_id_crc8.sv
// Bit-serial CRC-8, MSB-first, init 0, no final XOR.
// Clear has priority over enable.
module user_id_crc8 #(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_din,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;
  logic       w_fb;

  assign w_fb = r_crc[7] ^ i_din;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? POLY : 8'h00);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/user_id_readout.sv
// Captures a tie-cell project ID, checks it with CRC-8, and exposes it through
// a word-read port and a serial dump (ID then CRC, MSB first).
module user_id_readout
  import user_id_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 32,
  parameter logic [7:0]  CRC_POLY = CRC8_POLY_DEFAULT,
  localparam int unsigned NWORDS  = ID_WIDTH / WORD_W,
  localparam int unsigned AW      = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [ID_WIDTH-1:0] id_raw,
  input  logic                rescan,
  output logic                ready,
  output logic [7:0]          crc,
  input  logic                rd_req,
  input  logic [AW-1:0]       rd_addr,
  output logic                rd_ack,
  output logic [31:0]         rd_data,
  input  logic                sh_start,
  output logic                sdo,
  output logic                sdo_valid,
  output logic                sh_busy
);

  localparam int unsigned DUMP_LEN = ID_WIDTH + 8;
  localparam int unsigned CW       = $clog2(DUMP_LEN) + 1;
  localparam int unsigned NSLOTS   = 2 ** AW;
  localparam logic [CW-1:0] SCAN_END = CW'(ID_WIDTH - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DUMP_LEN);

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_idq;
  logic [DUMP_LEN-1:0]   r_shreg;
  logic [CW-1:0]         r_cnt;
  logic                  r_ready;
  logic                  r_sdo_valid;
  logic                  r_rd_ack;
  logic [31:0]           r_rd_data;

  logic [7:0]            w_crc;
  logic                  w_crc_clr;
  logic                  w_crc_en;
  logic [31:0]           w_words [NSLOTS];

  // One shift register serves both phases: it carries the ID into the CRC
  // during SCAN (draining to zero) and carries ID+CRC onto sdo during SHIFT.
  assign w_crc_clr = (r_state == ST_SNAP);
  assign w_crc_en  = (r_state == ST_SCAN);

  user_id_crc8 #(
    .POLY(CRC_POLY)
  ) u_crc (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (w_crc_clr),
    .i_en   (w_crc_en),
    .i_din  (r_shreg[DUMP_LEN-1]),
    .o_crc  (w_crc)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_SNAP;
      r_idq       <= '0;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_sdo_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_SNAP: begin
          r_idq   <= id_raw;
          r_shreg <= {id_raw, 8'h00};
          r_cnt   <= '0;
          r_state <= rescan ? ST_SNAP : ST_SCAN;
        end
        ST_SCAN: begin
          r_shreg <= {r_shreg[DUMP_LEN-2:0], 1'b0};
          r_cnt   <= r_cnt + 1'b1;
          if (rescan) begin
            r_state <= ST_SNAP;
          end else if (r_cnt == SCAN_END) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end
        end
        ST_READY: begin
          if (rescan) begin
            r_state <= ST_SNAP;
            r_ready <= 1'b0;
          end else if (sh_start) begin
            r_state     <= ST_SHIFT;
            r_shreg     <= {r_idq, w_crc};
            r_cnt       <= CW'(1);
            r_sdo_valid <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_shreg <= {r_shreg[DUMP_LEN-2:0], 1'b0};
          if (r_cnt == LAST_CNT) begin
            r_state     <= ST_READY;
            r_sdo_valid <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_SNAP;
      endcase
    end
  end

  // Unused address slots read as zero, covering rd_addr >= NWORDS.
  for (genvar g = 0; g < NSLOTS; g++) begin : g_word
    if (g < NWORDS) begin : g_used
      assign w_words[g] = r_idq[g*WORD_W +: WORD_W];
    end else begin : g_pad
      assign w_words[g] = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_ack  <= rd_req;
      r_rd_data <= (rd_req && r_ready) ? w_words[rd_addr] : '0;
    end
  end

  assign ready     = r_ready;
  assign crc       = w_crc;
  assign rd_ack    = r_rd_ack;
  assign rd_data   = r_rd_data;
  assign sdo       = r_shreg[DUMP_LEN-1] & r_sdo_valid;
  assign sdo_valid = r_sdo_valid;
  assign sh_busy   = r_sdo_valid;

endmodule

// File: tb/tb_user_id_readout.sv
// Bench for user_id_readout: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_user_id_readout;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [W-1:0]  id_raw;
  logic          rescan, rd_req, sh_start;
  logic [0:0]    rd_addr;
  logic          ready, rd_ack, sdo, sdo_valid, sh_busy;
  logic [7:0]    crc;
  logic [31:0]   rd_data;

  logic [95:0]   id96;
  logic          rd_req96;
  logic [1:0]    rd_addr96;
  logic          ready96, rd_ack96, sdo96, sdo_valid96, sh_busy96;
  logic [7:0]    crc96;
  logic [31:0]   rd_data96;
  logic          zero = 1'b0;

  always #5 clk = ~clk;

  user_id_readout u_dut (
    .clk(clk), .resetn(resetn), .id_raw(id_raw), .rescan(rescan),
    .ready(ready), .crc(crc), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data), .sh_start(sh_start),
    .sdo(sdo), .sdo_valid(sdo_valid), .sh_busy(sh_busy)
  );

  user_id_readout #(.ID_WIDTH(96)) u_dut96 (
    .clk(clk), .resetn(resetn), .id_raw(id96), .rescan(zero),
    .ready(ready96), .crc(crc96), .rd_req(rd_req96), .rd_addr(rd_addr96),
    .rd_ack(rd_ack96), .rd_data(rd_data96), .sh_start(zero),
    .sdo(sdo96), .sdo_valid(sdo_valid96), .sh_busy(sh_busy96)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-wise CRC-8 (poly 0x07), most-significant byte first.
  function automatic logic [7:0] crc8_ref(input logic [W-1:0] v);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    for (int i = W/8 - 1; i >= 0; i--) begin
      b = v[i*8 +: 8];
      c = c ^ b;
      for (int k = 0; k < 8; k++) c = {c[6:0], 1'b0} ^ (c[7] ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Model: cycles left until ready, pending snapshot, queue of dump bits, read result.
  int            m_left = W + 1;
  bit            m_cap  = 1'b1;
  logic [W-1:0]  m_idq  = '0;
  bit            m_bits[$];
  logic          m_ack  = 1'b0;
  logic [31:0]   m_data = '0;

  initial begin
    forever begin
      bit dumping;
      bit rdy;
      logic [W+7:0] s;
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_left = W + 1;
        m_cap  = 1'b1;
        m_idq  = '0;
        m_bits.delete();
        m_ack  = 1'b0;
        m_data = '0;
      end else begin
        dumping = (m_bits.size() > 0);
        rdy     = (m_left == 0);
        m_ack   = rd_req;
        m_data  = (rd_req && rdy && rd_addr == 1'b0) ? m_idq : 32'h0;
        if (dumping) void'(m_bits.pop_front());
        if (m_cap) begin
          m_idq = id_raw;
          m_cap = 1'b0;
        end
        if (rescan && !dumping) begin
          m_left = W + 1;
          m_cap  = 1'b1;
        end else begin
          if (m_left > 0) m_left--;
          if (sh_start && rdy && !dumping) begin
            s = {m_idq, crc8_ref(m_idq)};
            for (int i = W + 7; i >= 0; i--) m_bits.push_back(s[i]);
          end
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      bit er;
      @(negedge clk);
      er = (m_left == 0);
      check("m_ready", ready, er);
      check("m_sdo_valid", sdo_valid, m_bits.size() > 0);
      check("m_sh_busy", sh_busy, m_bits.size() > 0);
      if (m_bits.size() > 0) check("m_sdo", sdo, m_bits[0]);
      if (er) check("m_crc", crc, crc8_ref(m_idq));
      check("m_rd_ack", rd_ack, m_ack);
      check("m_rd_data", rd_data, m_data);
    end
  end

  task automatic read32(input logic a, input logic [31:0] exp, input string tag);
    rd_addr = a;
    rd_req  = 1'b1;
    @(negedge clk);
    rd_req  = 1'b0;
    check({tag, "_ack"}, rd_ack, 1'b1);
    check({tag, "_data"}, rd_data, exp);
  endtask

  task automatic do_rescan(input logic [31:0] v, input logic [7:0] exp_crc, input string tag);
    int n;
    id_raw = v;
    rescan = 1'b1;
    @(negedge clk);
    rescan = 1'b0;
    n = 0;
    while (!ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_low_cycles"}, n, 33);
    check({tag, "_crc"}, crc, exp_crc);
    read32(1'b0, v, {tag, "_rd"});
  endtask

  // Runs a dump; at poke_at valid cycles, pulses rescan+sh_start (ignored in SHIFT).
  task automatic run_dump(input int poke_at, output int len, output logic [39:0] bits);
    sh_start = 1'b1;
    @(negedge clk);
    sh_start = 1'b0;
    len  = 0;
    bits = '0;
    while (sdo_valid && len < 100) begin
      bits = {bits[38:0], sdo};
      len++;
      if (len == poke_at) begin
        rescan = 1'b1;
        sh_start = 1'b1;
      end else begin
        rescan = 1'b0;
        sh_start = 1'b0;
      end
      @(negedge clk);
    end
    rescan = 1'b0;
    sh_start = 1'b0;
  endtask

  initial begin
    int n;
    int len;
    int seen;
    logic [39:0] bits;

    id_raw = 32'h12012025; rescan = 0; rd_req = 0; rd_addr = 0; sh_start = 0;
    id96 = 96'hA5A5A5A5_DEADBEEF_01234567; rd_req96 = 0; rd_addr96 = 0;

    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b0);
    check("rst_sdo_valid", sdo_valid, 1'b0);
    check("rst_crc", crc, 8'h00);
    check("rst_rd_data", rd_data, 32'h0);

    resetn = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 5) begin rd_req = 1'b1; rd_addr = 1'b0; end
      if (n == 6) begin
        check("early_rd_ack", rd_ack, 1'b1);
        check("early_rd_data", rd_data, 32'h0);
        rd_req = 1'b0;
      end
      sh_start = (n == 10);
      if (ready) break;
    end
    sh_start = 1'b0;
    check("ready_latency", n, 33);

    // Back-to-back reads: word 0, then out-of-range word 1, then idle.
    rd_addr = 1'b0; rd_req = 1'b1;
    @(negedge clk);
    check("b2b_ack0", rd_ack, 1'b1);
    check("b2b_data0", rd_data, 32'h12012025);
    rd_addr = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check("b2b_ack1", rd_ack, 1'b1);
    check("b2b_data1", rd_data, 32'h0);
    @(negedge clk);
    check("b2b_idle_ack", rd_ack, 1'b0);

    do_rescan(32'h00000080, 8'h89, "crc80");
    do_rescan(32'h00000000, 8'h00, "crc00");
    do_rescan(32'h00000001, 8'h07, "crc01");

    run_dump(-1, len, bits);
    check("dump_len", len, 40);
    check("dump_bits", bits, 40'h00_0000_0107);
    check("dump_busy_after", sh_busy, 1'b0);

    run_dump(5, len, bits);
    check("dump_poke_len", len, 40);
    check("dump_poke_bits", bits, 40'h00_0000_0107);
    check("dump_poke_ready", ready, 1'b1);
    repeat (2) @(negedge clk);

    // Same-cycle rescan and sh_start: rescan wins, no dump.
    rescan = 1'b1; sh_start = 1'b1;
    @(negedge clk);
    rescan = 1'b0; sh_start = 1'b0;
    check("collide_ready", ready, 1'b0);
    n = 0; seen = 0;
    while (!ready && n < 200) begin
      if (sdo_valid) seen++;
      n++;
      @(negedge clk);
    end
    check("collide_low_cycles", n, 33);
    check("collide_no_dump", seen, 0);

    // Asynchronous reset in the middle of a dump.
    sh_start = 1'b1;
    @(negedge clk);
    sh_start = 1'b0;
    n = 0;
    while (sdo_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("abort_reached_bit10", n, 10);
    #2 resetn = 1'b0;
    #1;
    check("abort_sdo_valid", sdo_valid, 1'b0);
    check("abort_sh_busy", sh_busy, 1'b0);
    check("abort_ready", ready, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    n = 0; seen = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
      if (sdo_valid) seen++;
    end
    check("abort_restart_latency", n, 33);
    check("abort_no_residual", seen, 0);

    // Wide instance: three words, address 3 out of range.
    n = 0;
    while (!ready96 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("w96_ready", ready96, 1'b1);
    for (int a = 0; a < 4; a++) begin
      logic [31:0] exp96;
      case (a)
        0: exp96 = 32'h01234567;
        1: exp96 = 32'hDEADBEEF;
        2: exp96 = 32'hA5A5A5A5;
        default: exp96 = 32'h0;
      endcase
      rd_addr96 = 2'(a);
      rd_req96  = 1'b1;
      @(negedge clk);
      rd_req96  = 1'b0;
      check("w96_ack", rd_ack96, 1'b1);
      check("w96_data", rd_data96, exp96);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
